// File: rtl/ddr_frame_arbiter.sv
// Burst arbiter between the camera write FIFO and the LCD read FIFO on a shared
// DDR user port. Manages a pair of ping-pong frame buffers.
module ddr_frame_arbiter #(
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_WORDS = 65280,
  parameter int unsigned ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BANK1_BASE = 24'h020000,
  parameter int unsigned RD_URGENT   = 32,
  parameter int unsigned FIFO_AW     = 10,
  parameter int unsigned FIFO_DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ddr_init_done,
  input  logic               frame_switch,
  input  logic               lcd_framesync,
  input  logic [FIFO_AW-1:0] wr_usedw,
  input  logic [FIFO_AW-1:0] rd_usedw,
  input  logic               cmd_ready,
  input  logic               burst_done,
  output logic               cmd_valid,
  output logic               cmd_write,
  output logic [ADDR_W-1:0]  cmd_addr,
  output logic [7:0]         cmd_len,
  output logic               frame_write_done,
  output logic               frame_read_done,
  output logic               wr_bank,
  output logic               rd_bank
);

  localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] wr_addr, wr_addr_d, rd_addr, rd_addr_d;
  logic [CNT_W-1:0] wr_sum, rd_sum;
  logic             wr_bank_d, rd_bank_d, wr_tgt;
  logic             last_rd, last_rd_d;
  logic             valid_vld, valid_vld_d, valid_bank, valid_bank_d;
  logic             rd_en, rd_en_d;
  logic             sw_pend, sw_pend_d, sync_pend, sync_pend_d;
  logic             cmd_valid_d, cmd_write_d, wdone_d, rdone_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic             wr_full, rd_in_frame, write_ok, read_ok, rd_urgent;

  // Eligibility of each direction as seen from IDLE
  assign wr_full     = (wr_addr == CNT_W'(FRAME_WORDS));
  assign rd_in_frame = rd_en && (32'(rd_addr) < FRAME_WORDS);
  assign write_ok    = (32'(wr_usedw) >= BURST_LEN) && (32'(wr_addr) < FRAME_WORDS);
  assign read_ok     = ((FIFO_DEPTH - 32'(rd_usedw)) >= BURST_LEN) && rd_in_frame;
  assign rd_urgent   = (32'(rd_usedw) < RD_URGENT);

  always_comb begin
    state_d      = state;
    wr_addr_d    = wr_addr;
    rd_addr_d    = rd_addr;
    wr_bank_d    = wr_bank;
    rd_bank_d    = rd_bank;
    last_rd_d    = last_rd;
    valid_vld_d  = valid_vld;
    valid_bank_d = valid_bank;
    rd_en_d      = rd_en;
    sw_pend_d    = sw_pend | frame_switch;
    sync_pend_d  = sync_pend | lcd_framesync;
    cmd_valid_d  = 1'b0;
    cmd_write_d  = cmd_write;
    cmd_addr_d   = cmd_addr;
    wdone_d      = 1'b0;
    rdone_d      = 1'b0;
    wr_tgt       = wr_bank;
    wr_sum       = wr_addr + CNT_W'(BURST_LEN);
    rd_sum       = rd_addr + CNT_W'(BURST_LEN);

    case (state)
      IDLE: begin
        if (sw_pend || sync_pend) begin
          // Frame switches take a whole IDLE cycle; write side first, then read side
          if (sw_pend) begin
            wr_tgt = wr_full ? ~wr_bank : wr_bank;
            if (rd_in_frame && (wr_tgt == rd_bank)) wr_tgt = wr_bank;
            wr_bank_d = wr_tgt;
            wr_addr_d = '0;
            sw_pend_d = frame_switch;
          end
          if (sync_pend) begin
            if (valid_vld) begin
              rd_bank_d = valid_bank;
              rd_addr_d = '0;
              rd_en_d   = 1'b1;
            end
            sync_pend_d = lcd_framesync;
          end
        end else if (ddr_init_done && (read_ok || write_ok)) begin
          cmd_valid_d = 1'b1;
          if (read_ok && (rd_urgent || !write_ok || !last_rd)) begin
            state_d     = RD_REQ;
            cmd_write_d = 1'b0;
            cmd_addr_d  = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rd_addr);
          end else begin
            state_d     = WR_REQ;
            cmd_write_d = 1'b1;
            cmd_addr_d  = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(wr_addr);
          end
        end
      end
      WR_REQ: begin
        cmd_valid_d = ~cmd_ready;
        if (cmd_ready) state_d = WR_BUSY;
      end
      RD_REQ: begin
        cmd_valid_d = ~cmd_ready;
        if (cmd_ready) state_d = RD_BUSY;
      end
      WR_BUSY: begin
        if (burst_done) begin
          wr_addr_d = wr_sum;
          last_rd_d = 1'b0;
          state_d   = IDLE;
          if (wr_sum == CNT_W'(FRAME_WORDS)) begin
            wdone_d      = 1'b1;
            valid_vld_d  = 1'b1;
            valid_bank_d = wr_bank;
          end
        end
      end
      RD_BUSY: begin
        if (burst_done) begin
          rd_addr_d = rd_sum;
          last_rd_d = 1'b1;
          state_d   = IDLE;
          if (rd_sum == CNT_W'(FRAME_WORDS)) rdone_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wr_addr          <= '0;
      rd_addr          <= '0;
      wr_bank          <= 1'b0;
      rd_bank          <= 1'b1;
      last_rd          <= 1'b1;
      valid_vld        <= 1'b0;
      valid_bank       <= 1'b0;
      rd_en            <= 1'b0;
      sw_pend          <= 1'b0;
      sync_pend        <= 1'b0;
      cmd_valid        <= 1'b0;
      cmd_write        <= 1'b0;
      cmd_addr         <= '0;
      cmd_len          <= 8'(BURST_LEN);
      frame_write_done <= 1'b0;
      frame_read_done  <= 1'b0;
    end else begin
      state            <= state_d;
      wr_addr          <= wr_addr_d;
      rd_addr          <= rd_addr_d;
      wr_bank          <= wr_bank_d;
      rd_bank          <= rd_bank_d;
      last_rd          <= last_rd_d;
      valid_vld        <= valid_vld_d;
      valid_bank       <= valid_bank_d;
      rd_en            <= rd_en_d;
      sw_pend          <= sw_pend_d;
      sync_pend        <= sync_pend_d;
      cmd_valid        <= cmd_valid_d;
      cmd_write        <= cmd_write_d;
      cmd_addr         <= cmd_addr_d;
      cmd_len          <= 8'(BURST_LEN);
      frame_write_done <= wdone_d;
      frame_read_done  <= rdone_d;
    end
  end

endmodule

// File: tb/tb_ddr_frame_arbiter.sv
// Bench for ddr_frame_arbiter: phase table, hand-written corner sequences and a
// randomized phase, all checked against a frame-level model of the two buffers.
module tb_ddr_frame_arbiter;

  localparam int unsigned BL = 64;
  localparam int unsigned FW = 65280;
  localparam logic [23:0] B1 = 24'h020000;

  logic        clk = 1'b0;
  logic        rst_n, ddr_init_done, frame_switch, lcd_framesync, cmd_ready, burst_done;
  logic [9:0]  wr_usedw, rd_usedw;
  logic        cmd_valid, cmd_write, frame_write_done, frame_read_done, wr_bank, rd_bank;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_len;

  ddr_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .frame_switch(frame_switch), .lcd_framesync(lcd_framesync),
    .wr_usedw(wr_usedw), .rd_usedw(rd_usedw), .cmd_ready(cmd_ready),
    .burst_done(burst_done), .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .frame_write_done(frame_write_done),
    .frame_read_done(frame_read_done), .wr_bank(wr_bank), .rd_bank(rd_bank)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int wd_cnt, rd_cnt;

  // Frame-level model: word counts per buffer, which buffer holds the last full frame
  int m_wr_words, m_rd_words;
  bit m_wb, m_rb, m_have_frame, m_frame_bank, m_reading, m_last_rd, m_psw, m_psync;

  typedef struct {
    bit sw; bit sy; int wr; int rd; int nb;
    bit wb; bit rb; int wd; int rdn;
  } row_t;
  row_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_wr_words = 0; m_rd_words = 0; m_wb = 0; m_rb = 1;
    m_have_frame = 0; m_frame_bank = 0; m_reading = 0; m_last_rd = 1;
    m_psw = 0; m_psync = 0;
  endtask

  // -1 none, 0 read, 1 write
  function automatic int m_pick();
    bit wok, rok;
    wok = (int'(wr_usedw) >= BL) && (m_wr_words < FW);
    rok = (1024 - int'(rd_usedw) >= BL) && m_reading && (m_rd_words < FW);
    if (rok && int'(rd_usedw) < 32) return 0;
    if (wok && rok) return m_last_rd ? 1 : 0;
    if (wok) return 1;
    if (rok) return 0;
    return -1;
  endfunction

  function automatic logic [23:0] m_addr(input int dir);
    int base;
    if (dir == 1) begin
      base = m_wb ? int'(B1) : 0;
      return 24'(base + m_wr_words);
    end
    base = m_rb ? int'(B1) : 0;
    return 24'(base + m_rd_words);
  endfunction

  task automatic m_apply();
    bit want;
    if (m_psw) begin
      want = (m_wr_words == FW) ? !m_wb : m_wb;
      if (m_reading && m_rd_words < FW && want == m_rb) want = m_wb;
      m_wb = want;
      m_wr_words = 0;
    end
    if (m_psync && m_have_frame) begin
      m_rb = m_frame_bank;
      m_rd_words = 0;
      m_reading = 1;
    end
    m_psw = 0; m_psync = 0;
  endtask

  // One command as the DDR controller sees it; checks direction, address and hold stability
  task automatic do_burst(input int ready_dly, input int sw_at, input bit rand_pulse);
    int dir, w, n, dly;
    bit wr, exp_wd, exp_rd, ps, py;
    logic [23:0] a;
    dir = m_pick();
    if (dir < 0) begin
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("no_cmd_when_ineligible", cmd_valid, 0);
      end
      return;
    end
    w = 0;
    while (cmd_valid !== 1'b1 && w < 50) begin tick(); w++; end
    if (cmd_valid !== 1'b1) begin
      chk("cmd_timeout", cmd_valid, 1);
      return;
    end
    wr = (dir == 1);
    a  = m_addr(dir);
    chk("cmd_write", cmd_write, wr);
    chk("cmd_addr", cmd_addr, a);
    chk("cmd_len", cmd_len, BL);
    chk("wr_bank", wr_bank, m_wb);
    chk("rd_bank", rd_bank, m_rb);
    dly = (ready_dly < 0) ? int'($urandom_range(0, 2)) : ready_dly;
    for (int i = 0; i < dly; i++) begin
      frame_switch = (i == sw_at);
      if (i == sw_at) m_psw = 1;
      tick();
      frame_switch = 0;
      chk("hold_valid", cmd_valid, 1);
      chk("hold_addr", cmd_addr, a);
      chk("hold_write", cmd_write, wr);
      chk("hold_wr_bank", wr_bank, m_wb);
    end
    cmd_ready = 1; tick(); cmd_ready = 0;
    chk("busy_no_valid", cmd_valid, 0);
    ps = rand_pulse && ($urandom_range(0, 511) == 0);
    py = rand_pulse && ($urandom_range(0, 255) == 0);
    frame_switch = ps; lcd_framesync = py;
    if (ps) m_psw = 1;
    if (py) m_psync = 1;
    n = $urandom_range(0, 3);
    tick();
    frame_switch = 0; lcd_framesync = 0;
    for (int i = 0; i < n; i++) tick();
    burst_done = 1; tick(); burst_done = 0;
    if (wr) begin m_wr_words += BL; m_last_rd = 0; end
    else    begin m_rd_words += BL; m_last_rd = 1; end
    exp_wd = wr && (m_wr_words == FW);
    exp_rd = !wr && (m_rd_words == FW);
    if (exp_wd) begin m_have_frame = 1; m_frame_bank = m_wb; end
    chk("frame_write_done", frame_write_done, exp_wd);
    chk("frame_read_done", frame_read_done, exp_rd);
    wd_cnt += int'(frame_write_done);
    rd_cnt += int'(frame_read_done);
    m_apply();
  endtask

  // Pulses issued while the arbiter has nothing to do
  task automatic quiet_pulse(input bit sw, input bit sy);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("quiet_no_cmd", cmd_valid, 0);
    end
    frame_switch = sw; lcd_framesync = sy;
    tick();
    frame_switch = 0; lcd_framesync = 0;
    m_psw = sw; m_psync = sy;
    m_apply();
    tick(); tick();
    chk("pulse_wr_bank", wr_bank, m_wb);
    chk("pulse_rd_bank", rd_bank, m_rb);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    tbl[0] = '{0, 0, 64,    0, 1020, 0, 1, 1, 0};
    tbl[1] = '{1, 0, 64,    0,    1, 1, 1, 0, 0};
    tbl[2] = '{0, 1, 64,  100, 2039, 1, 0, 1, 1};
    tbl[3] = '{1, 1, 64,   10,    3, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 64, 1023, 1020, 0, 1, 1, 0};
    tbl[5] = '{1, 0, 64, 1023,    1, 0, 1, 0, 0};
    tbl[6] = '{0, 1,  0,  100,    5, 0, 0, 0, 0};

    rst_n = 0; ddr_init_done = 0; frame_switch = 0; lcd_framesync = 0;
    cmd_ready = 0; burst_done = 0; wr_usedw = 64; rd_usedw = 0;
    model_reset();
    tick(); tick();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_write", cmd_write, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_len", cmd_len, BL);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_wdone", frame_write_done, 0);
    chk("rst_rdone", frame_read_done, 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_cmd_before_init", cmd_valid, 0);
    end
    ddr_init_done = 1;

    for (int r = 0; r < 7; r++) begin
      if (tbl[r].sw || tbl[r].sy) quiet_pulse(tbl[r].sw, tbl[r].sy);
      wr_usedw = 10'(tbl[r].wr); rd_usedw = 10'(tbl[r].rd);
      wd_cnt = 0; rd_cnt = 0;
      for (int b = 0; b < tbl[r].nb; b++) do_burst(-1, -1, 0);
      wr_usedw = 0; rd_usedw = 1023;
      tick(); tick();
      chk("row_wr_bank", wr_bank, tbl[r].wb);
      chk("row_rd_bank", rd_bank, tbl[r].rb);
      chk("row_write_frames", wd_cnt, tbl[r].wd);
      chk("row_read_frames", rd_cnt, tbl[r].rdn);
    end

    // cmd_ready stalled in WR_REQ with a frame switch arriving meanwhile
    wr_usedw = 64; rd_usedw = 1023;
    do_burst(5, 2, 0);
    do_burst(-1, -1, 0);
    chk("stall_switch_wr_bank", wr_bank, 0);

    // Randomized FIFO levels and frame pulses
    for (int b = 0; b < 1500; b++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 5))
          0: wr_usedw = 0;   1: wr_usedw = 30;  2: wr_usedw = 63;
          3: wr_usedw = 64;  4: wr_usedw = 500; default: wr_usedw = 1023;
        endcase
        case ($urandom_range(0, 8))
          0: rd_usedw = 0;   1: rd_usedw = 10;  2: rd_usedw = 31;
          3: rd_usedw = 32;  4: rd_usedw = 100; 5: rd_usedw = 959;
          6: rd_usedw = 960; 7: rd_usedw = 961; default: rd_usedw = 1023;
        endcase
      end
      do_burst(-1, -1, 1);
    end

    // Reset asserted while a read burst is outstanding
    wr_usedw = 0; rd_usedw = 1023;
    tick(); tick();
    quiet_pulse(0, 1);
    rd_usedw = 100;
    w = 0;
    while (cmd_valid !== 1'b1 && w < 50) begin tick(); w++; end
    chk("rstbusy_cmd_valid", cmd_valid, 1);
    chk("rstbusy_is_read", cmd_write, 0);
    cmd_ready = 1; tick(); cmd_ready = 0;
    tick();
    rst_n = 0;
    #2;
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_wr_bank", wr_bank, 0);
    chk("midrst_rd_bank", rd_bank, 1);
    chk("midrst_cmd_addr", cmd_addr, 0);
    chk("midrst_wdone", frame_write_done, 0);
    chk("midrst_rdone", frame_read_done, 0);
    model_reset();
    tick(); tick();
    rst_n = 1;
    wr_usedw = 64; rd_usedw = 100;
    for (int b = 0; b < 3; b++) do_burst(-1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
